// File: rtl/i2s_readout_ctrl_pkg.sv
// Shared types for the I2S capture-buffer readout path.
package i2s_pkg;

    localparam int SAMPLE_W = 24;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        FETCH   = 3'd2,
        LATCH   = 3'd3,
        PRESENT = 3'd4
    } readout_state_t;

endpackage

// File: rtl/i2s_readout_ctrl_if.sv
// Capture-buffer and host handshake bundle; slave is the controller side.
interface i2s_readout_ctrl_if
    import i2s_pkg::*;
#(
    parameter int ADDR_W = 6
) ();

    logic                wr_done;
    logic [ADDR_W-1:0]   wr_addr;
    logic                rd_req;
    logic                buf_rd;
    logic [ADDR_W-1:0]   buf_raddr;
    logic [SAMPLE_W-1:0] buf_rdata;
    logic [SAMPLE_W-1:0] data;
    logic                data_valid;

    modport slave (
        input  wr_done, rd_req, buf_rdata,
        output wr_addr, buf_rd, buf_raddr, data, data_valid
    );

    modport master (
        output wr_done, rd_req, buf_rdata,
        input  wr_addr, buf_rd, buf_raddr, data, data_valid
    );

endinterface

// File: rtl/i2s_ptr_tracker.sv
// Write/read pointers and fill level of the capture ring buffer.
module i2s_ptr_tracker #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inc_wr,
    input  logic              inc_rd,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W:0]   fill,
    output logic [ADDR_W:0]   fill_nxt,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    logic wr_ok;
    logic rd_ok;

    assign full  = (fill == DEPTH);
    assign empty = (fill == '0);
    assign wr_ok = inc_wr && !full;
    assign rd_ok = inc_rd && !empty;

    always_comb begin
        fill_nxt = fill;
        if (flush)
            fill_nxt = '0;
        else if (wr_ok && !rd_ok)
            fill_nxt = fill + ONE;
        else if (!wr_ok && rd_ok)
            fill_nxt = fill - ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            wr_ptr <= wr_ptr + ADDR_W'(wr_ok);
            rd_ptr <= rd_ptr + ADDR_W'(rd_ok);
            fill   <= fill_nxt;
        end
    end

endmodule

// File: rtl/i2s_readout_ctrl.sv
// Readout controller: host handshake FSM, fill interrupt, overflow tracking.
// Define I2S_READOUT_OVF_COUNT_EN to add the saturating ovf_count output.
//
// state   | meaning
// IDLE    | disabled, pointers flushed
// RUN     | waiting for a host request with data available
// FETCH   | buffer read strobe issued
// LATCH   | capture buffer data into the host register
// PRESENT | word held valid until host drops rd_req
module i2s_readout_ctrl
    import i2s_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int HI_WM  = 32,
    parameter int LO_WM  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              ovf_clr,
    i2s_readout_ctrl_if.slave bus,
    output logic              rpi_interrupt,
    output logic [ADDR_W:0]   fill,
    output logic              overflow
`ifdef I2S_READOUT_OVF_COUNT_EN
    ,
    output logic [15:0]       ovf_count
`endif
);

    localparam logic [2:0] S_IDLE    = 3'(IDLE);
    localparam logic [2:0] S_RUN     = 3'(RUN);
    localparam logic [2:0] S_FETCH   = 3'(FETCH);
    localparam logic [2:0] S_LATCH   = 3'(LATCH);
    localparam logic [2:0] S_PRESENT = 3'(PRESENT);

    localparam logic [ADDR_W:0] HI = (ADDR_W+1)'(HI_WM);
    localparam logic [ADDR_W:0] LO = (ADDR_W+1)'(LO_WM);

    logic [2:0]          state;
    logic [SAMPLE_W-1:0] data_q;
    logic                data_valid_q;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     fill_nxt;
    logic                full;
    logic                empty;
    logic                wr_req;
    logic                drop;

    // Writes are ignored while IDLE, including the edge that leaves IDLE.
    assign wr_req = bus.wr_done && enable && (state != S_IDLE);
    assign drop   = wr_req && full;

    i2s_ptr_tracker #(.ADDR_W(ADDR_W)) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .flush    (!enable),
        .inc_wr   (wr_req),
        .inc_rd   (state == S_LATCH),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .fill     (fill),
        .fill_nxt (fill_nxt),
        .full     (full),
        .empty    (empty)
    );

    assign bus.wr_addr    = wr_ptr;
    assign bus.buf_raddr  = rd_ptr;
    assign bus.buf_rd     = (state == S_FETCH);
    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else if (!enable) begin
            state        <= S_IDLE;
            data_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  state <= S_RUN;
                S_RUN:   if (bus.rd_req && !empty) state <= S_FETCH;
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    data_q       <= bus.buf_rdata;
                    data_valid_q <= 1'b1;
                    state        <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (!bus.rd_req) begin
                        data_valid_q <= 1'b0;
                        state        <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rpi_interrupt <= 1'b0;
        else if (!enable)
            rpi_interrupt <= 1'b0;
        else if (fill_nxt >= HI)
            rpi_interrupt <= 1'b1;
        else if (fill_nxt <= LO)
            rpi_interrupt <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

`ifdef I2S_READOUT_OVF_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_count <= '0;
        else if (ovf_clr)
            ovf_count <= drop ? 16'd1 : 16'd0;
        else if (drop && ovf_count != 16'hFFFF)
            ovf_count <= ovf_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_i2s_readout_ctrl.sv
// Scoreboard bench for i2s_readout_ctrl: word-queue reference model plus directed cases.
module tb_i2s_readout_ctrl;
    import i2s_pkg::*;

    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int HI    = 32;
    localparam int LO    = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          rpi_interrupt;
    logic          overflow;
    logic [AW:0]   fill;
`ifdef I2S_READOUT_OVF_COUNT_EN
    logic [15:0]   ovf_count;
`endif

    i2s_readout_ctrl_if #(.ADDR_W(AW)) bus ();

    i2s_readout_ctrl #(.ADDR_W(AW), .HI_WM(HI), .LO_WM(LO)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .ovf_clr       (ovf_clr),
        .bus           (bus),
        .rpi_interrupt (rpi_interrupt),
        .fill          (fill),
        .overflow      (overflow)
`ifdef I2S_READOUT_OVF_COUNT_EN
        ,
        .ovf_count     (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of unread words, a write pointer, sticky flags.
    logic [23:0] mem [DEPTH];
    logic [23:0] exp_q [$];
    logic [23:0] wdata = '0;
    int          m_wptr = 0;
    int          m_cnt = 0;
    bit          m_run = 0;
    bit          m_ovf = 0;
    bit          m_int = 0;
    bit          prev_dv = 0;
    bit          rd_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [23:0] w);
        wdata = w;
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
    endtask

    task automatic wait_dv(output int lat);
        lat = 0;
        while (!bus.data_valid && lat < 300) begin
            tick();
            lat++;
        end
        if (!bus.data_valid) begin
            checks++;
            errors++;
            $display("FAIL read_timeout data_valid=0 required=1 at %0t", $time);
        end
    endtask

    task automatic host_read(input int hold, output int lat, output logic [23:0] d);
        bus.rd_req = 1'b1;
        wait_dv(lat);
        d = bus.data;
        repeat (hold) tick();
        bus.rd_req = 1'b0;
        tick();
        chk("dv_release", 32'(bus.data_valid), 0);
    endtask

    // Model update on each active edge (pre-edge inputs).
    initial begin
        bus.buf_rdata = '0;
        forever begin
            bit dropped;
            @(posedge clk or posedge rst);
            dropped = 0;
            if (rst) begin
                exp_q.delete();
                m_wptr = 0; m_run = 0; m_ovf = 0; m_int = 0; m_cnt = 0;
                bus.buf_rdata <= '0;
            end else begin
                if (bus.buf_rd)
                    bus.buf_rdata <= mem[bus.buf_raddr];
                if (!enable) begin
                    exp_q.delete();
                    m_wptr = 0; m_run = 0; m_int = 0;
                end else begin
                    if (m_run && bus.wr_done) begin
                        if (exp_q.size() < DEPTH) begin
                            mem[m_wptr] <= wdata;
                            exp_q.push_back(wdata);
                            m_wptr = (m_wptr + 1) % DEPTH;
                        end else begin
                            dropped = 1;
                        end
                    end
                    m_run = 1;
                end
                if (dropped) m_ovf = 1;
                else if (ovf_clr) m_ovf = 0;
                if (ovf_clr) m_cnt = dropped ? 1 : 0;
                else if (dropped && m_cnt < 65535) m_cnt++;
            end
        end
    end

    // Monitor: pops a word whenever data_valid rises, then checks status outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.data_valid && !prev_dv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data_unexpected data=%0h required=no_word at %0t", bus.data, $time);
                end else begin
                    chk("data", 32'(bus.data), 32'(exp_q.pop_front()));
                end
            end
            prev_dv = bus.data_valid;
            if (!rst) begin
                if (exp_q.size() >= HI) m_int = 1;
                else if (exp_q.size() <= LO) m_int = 0;
            end
            chk("fill", 32'(fill), 32'(exp_q.size()));
            chk("wr_addr", 32'(bus.wr_addr), 32'(m_wptr));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("rpi_interrupt", 32'(rpi_interrupt), 32'(m_int));
`ifdef I2S_READOUT_OVF_COUNT_EN
            chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time_limit_reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [23:0] d;

        bus.wr_done = 1'b0;
        bus.rd_req  = 1'b0;
        repeat (2) tick();
        chk("rst_fill", 32'(fill), 0);
        chk("rst_dv", 32'(bus.data_valid), 0);
        chk("rst_buf_rd", 32'(bus.buf_rd), 0);
        chk("rst_data", 32'(bus.data), 0);

        rst = 1'b0;
        enable = 1'b1;
        tick();

        wr(24'hA5A5A5);
        wr(24'h5A5A5A);
        host_read(1, lat, d);
        chk("lat_first", 32'(lat), 3);
        chk("data_first", 32'(d), 32'h00A5A5A5);
        host_read(0, lat, d);
        chk("lat_second", 32'(lat), 3);
        chk("data_second", 32'(d), 32'h005A5A5A);
        chk("fill_drained", 32'(fill), 0);

        for (int i = 0; i < 31; i++) wr(24'($urandom));
        chk("int_below_hi", 32'(rpi_interrupt), 0);
        wr(24'($urandom));
        chk("int_at_hi", 32'(rpi_interrupt), 1);
        chk("fill_32", 32'(fill), 32);

        enable = 1'b0;
        tick();
        chk("flush_fill", 32'(fill), 0);
        chk("flush_int", 32'(rpi_interrupt), 0);
        enable = 1'b1;
        tick();

        for (int i = 0; i < 65; i++) wr(24'($urandom));
        chk("full_fill", 32'(fill), 64);
        chk("full_ovf", 32'(overflow), 1);
        chk("full_wr_addr", 32'(bus.wr_addr), 0);
`ifdef I2S_READOUT_OVF_COUNT_EN
        chk("full_ovf_count", 32'(ovf_count), 1);
`endif
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);
        ovf_clr = 1'b1;
        wr(24'($urandom));
        ovf_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 1);

        for (int i = 0; i < 54; i++) host_read(0, lat, d);
        chk("fill_10", 32'(fill), 10);

        // wr_done lands on the LATCH edge: fill must not move.
        bus.rd_req = 1'b1;
        tick();
        tick();
        wdata = 24'h123456;
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        chk("coinc_fill", 32'(fill), 10);
        chk("coinc_wr_addr", 32'(bus.wr_addr), 1);
        chk("coinc_raddr", 32'(bus.buf_raddr), 55);
        bus.rd_req = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) host_read(0, lat, d);
        chk("empty_fill", 32'(fill), 0);
        chk("empty_int", 32'(rpi_interrupt), 0);

        bus.rd_req = 1'b1;
        repeat (5) tick();
        chk("wait_empty_dv", 32'(bus.data_valid), 0);
        wr(24'hC0FFEE);
        wait_dv(lat);
        chk("wait_empty_lat", 32'(lat), 3);
        chk("wait_empty_data", 32'(bus.data), 32'h00C0FFEE);
        bus.rd_req = 1'b0;
        tick();

        wr(24'h0BEEF0);
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        tick();
        tick();
        chk("early_drop_dv", 32'(bus.data_valid), 1);
        tick();
        chk("early_drop_exit", 32'(bus.data_valid), 0);
        chk("early_drop_fill", 32'(fill), 0);

        fork
            begin
                while (!rd_done) begin
                    ovf_clr = ($urandom_range(49) == 0);
                    if ($urandom_range(2) == 0) wr(24'($urandom));
                    else tick();
                    ovf_clr = 1'b0;
                end
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    int gap;
                    gap = $urandom_range(4);
                    repeat (gap) tick();
                    host_read($urandom_range(3), lat, d);
                end
                rd_done = 1;
            end
        join

        wr(24'h777777);
        bus.rd_req = 1'b1;
        wait_dv(lat);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_dv", 32'(bus.data_valid), 0);
        chk("async_rst_data", 32'(bus.data), 0);
        chk("async_rst_fill", 32'(fill), 0);
        chk("async_rst_ovf", 32'(overflow), 0);
        chk("async_rst_int", 32'(rpi_interrupt), 0);
        chk("async_rst_wr_addr", 32'(bus.wr_addr), 0);
        bus.rd_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
